// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, 3-sample majority vote per bit, LSB-first deserialiser with parity/stop checks.
// Latency: result pulse one cycle after the stop bit's last edge (cycle 11*PRESCALE with parity, 10*PRESCALE without, for 8 data bits).
// Backpressure: none; Data_Valid/PAR_Err/STP_Err are single-cycle pulses that the consumer must take when they occur.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_Err,
  output logic                  STP_Err
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_q;

  logic                  bit_end;
  logic                  voted;
  logic                  start_det;
  logic                  shift_en;
  logic                  par_chk;
  logic                  frame_end;

  assign bit_end = (state_q != S_IDLE) && (edge_cnt == EDGE_LAST);
  assign voted   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  // State register; reset drops any partial frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: every decision is taken on the last edge of a bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!RX_IN) state_d = S_START;
      S_START:  if (bit_end) state_d = voted ? S_IDLE : S_DATA;
      S_DATA:   if (bit_end && (bit_cnt == BIT_LAST)) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    start_det = (state_q == S_IDLE) && !RX_IN;
    shift_en  = (state_q == S_DATA) && bit_end;
    par_chk   = (state_q == S_PARITY) && bit_end;
    frame_end = (state_q == S_STOP) && bit_end;
  end

  // Edge counter: the start-detect cycle is edge 0, so the next cycle is edge 1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                      edge_cnt <= '0;
    else if (start_det)                           edge_cnt <= EW'(1);
    else if ((state_q == S_IDLE) || bit_end)      edge_cnt <= '0;
    else                                          edge_cnt <= edge_cnt + EW'(1);
  end

  // Data bit counter, cleared at each new frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            bit_cnt <= '0;
    else if (start_det) bit_cnt <= '0;
    else if (shift_en)  bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
  end

  // Capture the three mid-bit samples used for the vote
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp <= '0;
    end else if (state_q != S_IDLE) begin
      if (edge_cnt == EDGE_S0) samp[0] <= RX_IN;
      if (edge_cnt == EDGE_S1) samp[1] <= RX_IN;
      if (edge_cnt == EDGE_S2) samp[2] <= RX_IN;
    end
  end

  // Frame context: parity mode latched at start detect, data shifted in LSB first
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_err_q <= 1'b0;
      end
      if (shift_en) shift_q <= {voted, shift_q[DATA_WIDTH-1:1]};
      if (par_chk)  par_err_q <= voted != ((^shift_q) ^ par_typ_q);
    end
  end

  // Frame result: good word updates P_DATA, otherwise flag the error(s) and keep P_DATA
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      PAR_Err    <= 1'b0;
      STP_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      PAR_Err    <= 1'b0;
      STP_Err    <= 1'b0;
      if (frame_end) begin
        if (voted && !par_err_q) begin
          P_DATA     <= shift_q;
          Data_Valid <= 1'b1;
        end else begin
          PAR_Err <= par_err_q;
          STP_Err <= !voted;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int P = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_Err;
  logic       STP_Err;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_Err    (PAR_Err),
    .STP_Err    (STP_Err)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges so far = index of the next rising edge
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  // Log every output pulse with the cycle it is visible in
  always @(negedge CLK) begin
    if (Data_Valid || PAR_Err || STP_Err) begin
      ev_t e;
      e.c  = cyc;
      e.dv = Data_Valid;
      e.pe = PAR_Err;
      e.se = STP_Err;
      e.d  = P_DATA;
      evq.push_back(e);
    end
  end

  int tests = 0;
  int fails = 0;
  int last_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input int idx, input int base, input int rel,
                        input logic dv, input logic pe, input logic se, input logic [7:0] d);
    if (idx >= evq.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: pulse %0d missing, got %0d pulses, expected at least %0d", name, idx, evq.size(), idx + 1);
    end else begin
      chk({name, "_cycle"}, evq[idx].c - base, rel);
      chk({name, "_flags{dv,pe,se}"}, int'({evq[idx].dv, evq[idx].pe, evq[idx].se}), int'({dv, pe, se}));
      chk({name, "_pdata"}, int'(evq[idx].d), int'(d));
    end
  endtask

  task automatic drive_bit(input logic b, input bit spike);
    RX_IN = b;
    if (spike) begin
      repeat (4) @(posedge CLK);
      #1 RX_IN = ~b;
      @(posedge CLK);
      #1 RX_IN = b;
      repeat (P - 5) @(posedge CLK);
      #1;
    end else begin
      repeat (P) @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int nbits);
    RX_IN = 1'b1;
    repeat (nbits * P) @(posedge CLK);
    #1;
  endtask

  // Frame bit spike_bit (start = 0) gets a one-cycle inverted spike at edge 4.
  // Parity mode is inverted after the start bit to show it is latched.
  task automatic send_frame(input logic [7:0] data, input logic pe, input logic pt,
                            input logic pbit, input logic stop, input int spike_bit);
    PAR_EN     = pe;
    PAR_TYP    = pt;
    last_start = cyc;
    drive_bit(1'b0, spike_bit == 0);
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
    for (int i = 0; i < 8; i++) drive_bit(data[i], spike_bit == i + 1);
    if (pe) drive_bit(pbit, spike_bit == 9);
    drive_bit(stop, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stop;
    logic       dv;
    logic       perr;
    logic       serr;
    int         lat;
    logic [7:0] pdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    logic [7:0] rd;

    // data, pe, pt, parity bit sent, stop sent, dv, perr, serr, pulse cycle, P_DATA after
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 88, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 88, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 88, 8'h3C};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80, 8'h81};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 88, 8'h5A};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 88, 8'h5A};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 88, 8'h80};

    RST     = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pdata", int'(P_DATA), 0);
    chk("reset_dv", int'(Data_Valid), 0);
    chk("reset_perr", int'(PAR_Err), 0);
    chk("reset_serr", int'(STP_Err), 0);
    RST = 1'b0;
    idle(2);

    // Two-cycle low glitch, then a real frame starting exactly at cycle 8
    evq.delete();
    base  = cyc;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    chk("glitch_pulse_count", evq.size(), 1);
    chk_ev("glitch_then_3c", 0, base, 96, 1'b1, 1'b0, 1'b0, 8'h3C);

    // Single-frame vectors
    for (int i = 0; i < 8; i++) begin
      evq.delete();
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].stop, -1);
      idle(2);
      chk($sformatf("vec%0d_pulse_count", i), evq.size(), 1);
      chk_ev($sformatf("vec%0d", i), 0, last_start, vecs[i].lat,
             vecs[i].dv, vecs[i].perr, vecs[i].serr, vecs[i].pdata);
      chk($sformatf("vec%0d_pdata_after", i), int'(P_DATA), int'(vecs[i].pdata));
    end

    // Three back-to-back frames with no idle gap, even parity
    evq.delete();
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    base = last_start;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    chk("b2b_pulse_count", evq.size(), 3);
    chk_ev("b2b_01", 0, base, 88, 1'b1, 1'b0, 1'b0, 8'h01);
    chk_ev("b2b_ff", 1, base, 176, 1'b1, 1'b0, 1'b0, 8'hFF);
    chk_ev("b2b_55", 2, base, 264, 1'b1, 1'b0, 1'b0, 8'h55);

    // One-cycle spike on data bit 2 at edge 4 is outvoted
    evq.delete();
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    idle(2);
    chk("spike_pulse_count", evq.size(), 1);
    chk_ev("spike_c3", 0, last_start, 88, 1'b1, 1'b0, 1'b0, 8'hC3);

    // Break: line held low; third start is cut short so it is rejected as a glitch
    evq.delete();
    PAR_EN = 1'b0;
    base   = cyc;
    RX_IN  = 1'b0;
    repeat (162) @(posedge CLK);
    #1;
    idle(3);
    chk("break_pulse_count", evq.size(), 2);
    chk_ev("break_1", 0, base, 80, 1'b0, 1'b0, 1'b1, 8'hC3);
    chk_ev("break_2", 1, base, 160, 1'b0, 1'b0, 1'b1, 8'hC3);

    // Reset for one cycle in the middle of data bit 4
    evq.delete();
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    rd      = 8'hE7;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], 1'b0);
    RX_IN = rd[4];
    repeat (4) @(posedge CLK);
    #1;
    RST   = 1'b1;
    RX_IN = 1'b1;
    #1;
    chk("midreset_pdata", int'(P_DATA), 0);
    chk("midreset_dv", int'(Data_Valid), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(8);
    chk("midreset_pulse_count", evq.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    chk("post_reset_pulse_count", evq.size(), 1);
    chk_ev("post_reset_5a", 0, last_start, 88, 1'b1, 1'b0, 1'b0, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
